// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder
//   Serial-to-parallel operand packer in front of the adder tree. Operands
//   arrive one per cycle on a valid/ready handshake. They are gathered into
//   a NUM_INPUTS-lane vector, and the vector is presented for exactly one
//   cycle with o_valid. A group that ends early (i_last) is zero-padded, so
//   the padded lanes add nothing to the tree sum.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   i_valid  in   operand valid
//   i_ready  out  feeder accepts an operand this cycle
//   i_data   in   DATAWIDTH-bit operand
//   i_last   in   final operand of the current group (forces emit)
//   o_valid  out  one-cycle pulse qualifying o_data / o_count
//   o_data   out  packed lanes; lane 0 is the first accepted operand
//   o_count  out  number of real (non-padded) lanes, 1..NUM_INPUTS
module adder_tree_feeder #(
  parameter int DATAWIDTH  = 4,
  parameter int NUM_INPUTS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  output logic                                  i_ready,
  input  logic [DATAWIDTH-1:0]                  i_data,
  input  logic                                  i_last,
  output logic                                  o_valid,
  output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  o_data,
  output logic [$clog2(NUM_INPUTS+1)-1:0]       o_count
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  xfer;

  // FILL is the only state that accepts. The tree cannot stall, so EMIT
  // drops ready for its single cycle instead of buffering a second vector.
  assign xfer = i_valid && (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FILL: begin
        if (xfer) begin
          buf_d[idx_q] = i_data;
          idx_d        = idx_q + IDX_W'(1);
          if ((idx_q == LAST_IDX) || i_last) begin
            state_d = S_EMIT;
            cnt_d   = CNT_W'(idx_q) + CNT_W'(1);
          end
        end
      end
      S_EMIT: begin
        // The buffer is cleared here. A short next group then reads zero in
        // its unused lanes without any masking at the output.
        state_d = S_FILL;
        idx_d   = '0;
        buf_d   = '0;
      end
      default: begin
        state_d = S_FILL;
        idx_d   = '0;
        buf_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is held low while rst is high, so no operand is taken during reset.
  assign i_ready = (state_q == S_FILL) && !rst;
  assign o_valid = (state_q == S_EMIT);
  assign o_data  = buf_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
module tb_adder_tree_feeder;

  localparam int DW = 4;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_valid = 1'b0;
  logic                  i_ready;
  logic [DW-1:0]         i_data = '0;
  logic                  i_last = 1'b0;
  logic                  o_valid;
  logic [N-1:0][DW-1:0]  o_data;
  logic [CW-1:0]         o_count;

  int checks = 0;
  int errors = 0;

  adder_tree_feeder #(.DATAWIDTH(DW), .NUM_INPUTS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  // Reference model: a list of operands for the group being collected, and
  // a record of the vector that the cycle after completion must present.
  int unsigned   grp[$];
  bit            m_known  = 0;
  bit            m_emit   = 0;
  bit            m_zero   = 0;
  logic [N*DW-1:0] exp_vec = '0;
  int            exp_cnt  = 0;
  int            exp_sum  = 0;
  int            emits    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic l);
    logic exp_ready;
    int   s;
    rst = r; i_valid = v; i_data = d; i_last = l;
    exp_ready = !r && !m_emit;
    @(negedge clk);
    if (m_known) begin
      check("i_ready", 32'(i_ready), 32'(exp_ready));
      check("o_valid", 32'(o_valid), 32'(m_emit));
      check("o_count", 32'(o_count), 32'(exp_cnt));
      if (m_emit) begin
        check("o_data", 32'(o_data), 32'(exp_vec));
        s = 0;
        for (int k = 0; k < int'(o_count) && k < N; k++) s += int'(o_data[k]);
        check("tree_sum", 32'(s), 32'(exp_sum));
      end
      if (m_zero) check("o_data_reset", 32'(o_data), 32'd0);
    end
    @(posedge clk);
    if (r) begin
      grp.delete();
      m_known = 1; m_emit = 0; m_zero = 1; exp_cnt = 0;
    end else if (m_emit) begin
      m_emit = 0;
    end else if (v) begin
      grp.push_back(int'(d));
      m_zero = 0;
      if (grp.size() == N || l) begin
        exp_vec = '0;
        exp_sum = 0;
        foreach (grp[k]) begin
          exp_vec[k*DW +: DW] = DW'(grp[k]);
          exp_sum += grp[k];
        end
        exp_cnt = grp.size();
        m_emit = 1;
        emits++;
        grp.delete();
      end
    end
    #1;
  endtask

  initial begin
    // Reset held two cycles with valid high: nothing may be accepted.
    step(1, 1, 4'd5, 0);
    step(1, 1, 4'd6, 0);
    // Full group 1,2,3,4 then the emit cycle.
    step(0, 1, 4'd1, 0);
    step(0, 1, 4'd2, 0);
    step(0, 1, 4'd3, 0);
    step(0, 1, 4'd4, 0);
    step(0, 0, 4'd0, 0);
    check("emits_full", 32'(emits), 32'd1);
    // Short groups: 7,9(last), then 15(last).
    step(0, 1, 4'd7, 0);
    step(0, 1, 4'd9, 1);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd15, 1);
    step(0, 0, 4'd0, 0);
    // Last on lane N-1: one emit only.
    step(0, 1, 4'd2, 0);
    step(0, 1, 4'd3, 0);
    step(0, 1, 4'd4, 0);
    step(0, 1, 4'd5, 1);
    step(0, 0, 4'd0, 0);
    step(0, 0, 4'd0, 0);
    check("emits_short", 32'(emits), 32'd4);
    // Continuous stream of 15s: valid held across both stall cycles.
    for (int k = 0; k < 9; k++) step(0, 1, 4'd15, 0);
    step(0, 0, 4'd0, 0);
    check("emits_cont", 32'(emits), 32'd6);
    // Gapped input.
    step(0, 1, 4'd3, 0);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd5, 0);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd6, 0);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd8, 0);
    step(0, 0, 4'd0, 0);
    // Reset mid-fill drops the partial group.
    step(0, 1, 4'd1, 0);
    step(0, 1, 4'd2, 0);
    step(1, 0, 4'd0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 4'd4, 0);
    step(0, 0, 4'd0, 0);
    check("emits_rstfill", 32'(emits), 32'd8);
    // Reset in the emit cycle.
    step(0, 1, 4'd1, 1);
    step(1, 1, 4'd2, 0);
    step(0, 0, 4'd0, 0);
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           DW'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
    end
    step(0, 0, 4'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Serial-to-parallel operand packer that sits upstream of the adder tree and drives its input interface.
- Accepts a stream of DATAWIDTH-bit operands on a valid/ready handshake and gathers them into a NUM_INPUTS-lane vector.
- Emits each vector with a one-cycle valid pulse; the tree has no backpressure, so every packed vector is presented exactly once.
- A short final group, marked by i_last, is zero-padded so the tree sum stays correct.

Parameters:
- DATAWIDTH, 4, bit-width of each operand lane.
- NUM_INPUTS, 16, lanes per emitted vector; legal range 2..32.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream operand valid.
- i_ready  output  1  feeder can accept an operand this cycle.
- i_data  input  DATAWIDTH  operand.
- i_last  input  1  qualifies i_data as the final operand of the current group; forces emit.
- o_valid  output  1  one-cycle pulse; o_data and o_count valid; connects to tree i_valid.
- o_data  output  [NUM_INPUTS-1:0][DATAWIDTH-1:0]  packed vector; lane 0 holds the first accepted operand; connects to tree in_data.
- o_count  output  $clog2(NUM_INPUTS+1)  number of real (non-padded) lanes in o_data, range 1..NUM_INPUTS.

Behaviour:
- Reset values:
  - i_ready=0 during the reset cycle, 1 on the first cycle after reset deassertion.
  - o_valid=0, o_data=all zeros, o_count=0.
  - State FILL, lane index idx=0, lane buffer cleared to zero.
- Transfer definition: an operand is accepted only when i_valid && i_ready on a rising edge.
- State FILL:
  - i_ready=1, o_valid=0.
  - On transfer: buffer[idx] <= i_data and idx <= idx+1.
  - If that transfer has idx==NUM_INPUTS-1 or i_last=1, the next state is EMIT and o_count is latched as idx+1.
  - With no transfer, state and buffer hold.
- State EMIT, lasting exactly one cycle:
  - o_valid=1.
  - o_data = buffer; lanes >= o_count read zero.
  - i_ready=0; i_valid is ignored and no operand is lost.
  - Next cycle: state FILL, idx=0, buffer cleared, o_count held until the next EMIT.
- o_data and o_count are register-driven and stable for the whole o_valid cycle.
- Latency: the operand that completes a group is accepted at edge N; o_valid is high in the cycle after edge N, and for exactly one cycle.
- Throughput: one full vector per NUM_INPUTS+1 cycles under continuous i_valid.
- Boundary conditions:
  - i_last on lane NUM_INPUTS-1 produces a single emit with o_count=NUM_INPUTS; no extra empty vector follows.
  - i_last on the first operand emits o_count=1 with only lane 0 nonzero.
  - An empty group is impossible, because i_last always travels with an operand.
  - i_valid held high across EMIT stalls one cycle; the same i_data is accepted on the following FILL cycle as lane 0.
  - rst asserted mid-FILL drops the partial group, and no emit follows.
  - rst asserted in EMIT takes priority: o_valid=0 in the cycle after the reset edge.
- Arithmetic: no summation here. Downstream tree sum = sum of lanes 0..o_count-1, zero padding contributes 0, and the tree output width must hold NUM_INPUTS*(2^DATAWIDTH-1).

Test Plan (NUM_INPUTS=4, DATAWIDTH=4):
- Reset: hold rst 2 cycles with i_valid=1 -> o_valid=0, o_data=0, o_count=0, nothing accepted; i_ready=1 the first cycle after release.
- Full group: stream 1,2,3,4 back-to-back, i_last=0 -> one o_valid pulse the cycle after operand 4, o_data lanes {1,2,3,4}, o_count=4, i_ready=0 that cycle; tree downstream reports 10.
- Short group: stream 7,9 with i_last on 9 -> o_data lanes {7,9,0,0}, o_count=2; next group 15 with i_last -> {15,0,0,0}, o_count=1.
- Continuous stream: 8 operands 15 each, i_valid always 1 -> two pulses 5 cycles apart, each with all lanes 15 and o_count=4; no operand dropped or duplicated across the stall.
- Gapped input: i_valid toggling 1,0,1,0 for operands 3,5,6,8 -> emit with {3,5,6,8} one cycle after 8 is accepted; the idle cycles do not advance idx.
- Reset mid-fill: accept 2 operands, assert rst 1 cycle, then send 4,4,4,4 -> single emit {4,4,4,4}, o_count=4; the earlier partial data never appears.
